// File: rtl/core_mem_responder.sv
// core_mem_responder
//   Single-port memory responder for the core's req/gnt memory interface.
//   Backs a word-addressed RAM, inserts programmable wait states, returns an
//   error response for addresses outside the RAM window, and flags requester
//   protocol violations with a sticky bit.
//
// Optional feature (macro CORE_MEM_RESPONDER_RAND_STALL_EN):
//   A 16-bit Fibonacci LFSR (taps 16,14,13,11, seed 16'hACE1) adds 0..3 extra
//   wait states per transaction. Absent when the macro is undefined.
//
// Ports:
//   clock      in   global clock
//   reset      in   synchronous active-high reset
//   mem_req    in   request valid, held until gnt
//   mem_addr   in   request byte address
//   mem_wen    in   write enable
//   mem_strb   in   byte write strobes
//   mem_wdata  in   write data
//   mem_gnt    out  one-cycle response pulse
//   mem_err    out  error response, valid with mem_gnt
//   mem_rdata  out  read data, valid with mem_gnt
//   busy       out  transaction captured and waiting
//   proto_err  out  sticky requester protocol violation
module core_mem_responder #(
    parameter int                ADDR_W    = 64,
    parameter int                DATA_W    = 64,
    parameter int                DEPTH     = 1024,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                LATENCY   = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  mem_req,
    input  logic [ADDR_W-1:0]     mem_addr,
    input  logic                  mem_wen,
    input  logic [DATA_W/8-1:0]   mem_strb,
    input  logic [DATA_W-1:0]     mem_wdata,
    output logic                  mem_gnt,
    output logic                  mem_err,
    output logic [DATA_W-1:0]     mem_rdata,
    output logic                  busy,
    output logic                  proto_err
);

    localparam int STRB_W = DATA_W / 8;
    localparam int LSB    = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(DEPTH);
    localparam int CNT_W  = 5;
    // One extra bit so the window size never overflows the address width.
    localparam logic [ADDR_W:0] RAM_SPAN = (ADDR_W + 1)'(DEPTH) << LSB;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q;
    logic                wen_q;
    logic [STRB_W-1:0]   strb_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_load;
    logic                err_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                proto_q;
    logic [DATA_W-1:0]   ram [DEPTH];

    logic [ADDR_W-1:0]   off;
    logic [IDX_W-1:0]    idx;
    logic                range_err;
    logic                viol;

    // Addresses below BASE_ADDR wrap to a large offset and fall out of range.
    assign off       = addr_q - BASE_ADDR;
    assign idx       = off[LSB +: IDX_W];
    assign range_err = ({1'b0, off} >= RAM_SPAN);

    assign viol = !mem_req || (mem_addr != addr_q) || (mem_wen != wen_q) ||
                  (mem_strb != strb_q) || (mem_wdata != wdata_q);

`ifdef CORE_MEM_RESPONDER_RAND_STALL_EN
    logic [15:0] lfsr_q;
    logic        lfsr_fb;

    assign lfsr_fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];

    always_ff @(posedge clock) begin
        if (reset) lfsr_q <= 16'hACE1;
        else       lfsr_q <= {lfsr_fb, lfsr_q[15:1]};
    end

    assign cnt_load = CNT_W'(LATENCY) + CNT_W'(lfsr_q[1:0]);
`else
    assign cnt_load = CNT_W'(LATENCY);
`endif

    // State register
    always_ff @(posedge clock) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (mem_req)      state_d = ST_WAIT;
            ST_WAIT: if (cnt_q == '0)  state_d = ST_RESP;
            ST_RESP:                   state_d = ST_IDLE;
            default:                   state_d = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        mem_gnt   = (state_q == ST_RESP);
        mem_err   = (state_q == ST_RESP) && err_q;
        busy      = (state_q == ST_WAIT);
        mem_rdata = rdata_q;
        proto_err = proto_q;
    end

    // Request capture, wait counter, response data and protocol checker
    always_ff @(posedge clock) begin
        if (reset) begin
            addr_q  <= '0;
            wen_q   <= 1'b0;
            strb_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            proto_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (mem_req) begin
                        addr_q  <= mem_addr;
                        wen_q   <= mem_wen;
                        strb_q  <= mem_strb;
                        wdata_q <= mem_wdata;
                        cnt_q   <= cnt_load;
                    end
                end
                ST_WAIT: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        err_q   <= range_err;
                        rdata_q <= range_err ? '0 : ram[idx];
                    end
                end
                default: ;
            endcase
            if ((state_q != ST_IDLE) && viol) proto_q <= 1'b1;
        end
    end

    // Backing RAM: not cleared by reset. Written on the edge ending RESP, so
    // the response carries the pre-write contents.
    always_ff @(posedge clock) begin
        if (!reset && (state_q == ST_RESP) && wen_q && !err_q) begin
            for (int unsigned b = 0; b < STRB_W; b++) begin
                if (strb_q[b]) ram[idx][b*8 +: 8] <= wdata_q[b*8 +: 8];
            end
        end
    end

endmodule

// File: tb/tb_core_mem_responder.sv
module tb_core_mem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    // Instance under main test: LATENCY=1
    logic        req = 1'b0;
    logic [63:0] addr = '0;
    logic        wen = 1'b0;
    logic [7:0]  strb = '0;
    logic [63:0] wdata = '0;
    logic        gnt, err, busy, proto;
    logic [63:0] rdata;

    // Second instance for back-to-back: LATENCY=0
    logic        req0 = 1'b0;
    logic [63:0] addr0 = '0;
    logic        gnt0, err0, busy0, proto0;
    logic [63:0] rdata0;

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;

    logic [15:0] lfsr_m;
    logic [15:0] lh [int];

    core_mem_responder #(.ADDR_W(64), .DATA_W(64), .DEPTH(1024),
                         .BASE_ADDR(64'h0), .LATENCY(1)) u_dut (
        .clock(clk), .reset(rst),
        .mem_req(req), .mem_addr(addr), .mem_wen(wen), .mem_strb(strb),
        .mem_wdata(wdata), .mem_gnt(gnt), .mem_err(err), .mem_rdata(rdata),
        .busy(busy), .proto_err(proto)
    );

    core_mem_responder #(.ADDR_W(64), .DATA_W(64), .DEPTH(1024),
                         .BASE_ADDR(64'h0), .LATENCY(0)) u_dut0 (
        .clock(clk), .reset(rst),
        .mem_req(req0), .mem_addr(addr0), .mem_wen(1'b0), .mem_strb(8'h00),
        .mem_wdata(64'h0), .mem_gnt(gnt0), .mem_err(err0), .mem_rdata(rdata0),
        .busy(busy0), .proto_err(proto0)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference LFSR (right-shifting Fibonacci, taps 16,14,13,11)
    always @(posedge clk) begin
        if (rst) lfsr_m <= 16'hACE1;
        else     lfsr_m <= {lfsr_m[0] ^ lfsr_m[2] ^ lfsr_m[3] ^ lfsr_m[5], lfsr_m[15:1]};
    end
    always @(negedge clk) lh[cyc] = lfsr_m;

    function automatic int extra(input int c);
`ifdef CORE_MEM_RESPONDER_RAND_STALL_EN
        logic [15:0] v;
        v = lh[c];
        return int'(v[1:0]);
`else
        return (c < 0) ? 0 : 0;
`endif
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One transaction on u_dut; returns response, cycles to gnt, expected
    // cycles to gnt, and whether busy was high in every wait cycle.
    task automatic txn(input logic [63:0] a, input logic w, input logic [7:0] s,
                       input logic [63:0] d, output logic [63:0] rd, output logic er,
                       output int k, output int k_exp, output logic busy_ok);
        int c0;
        logic seen;
        @(negedge clk);
        req = 1'b1; addr = a; wen = w; strb = s; wdata = d;
        c0 = cyc; k = 0; seen = 1'b0; busy_ok = 1'b1;
        k_exp = 3 + extra(c0);
        while (!seen && k < 40) begin
            @(negedge clk);
            k++;
            if (gnt) seen = 1'b1;
            else if (!busy) busy_ok = 1'b0;
        end
        if (!seen) check("gnt_timeout", 64'd0, 64'd1);
        rd = rdata; er = err;
        @(posedge clk); #1;
        req = 1'b0; wen = 1'b0; strb = '0;
    endtask

    initial begin
        logic [63:0] rd;
        logic        er, bok, any_gnt;
        int          k, ke, c0, ng;
        int          g [2];

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_gnt",   {63'd0, gnt},   64'd0);
        check("rst_err",   {63'd0, err},   64'd0);
        check("rst_rdata", rdata,          64'd0);
        check("rst_busy",  {63'd0, busy},  64'd0);
        check("rst_proto", {63'd0, proto}, 64'd0);

        // Nominal read
        txn(64'h0, 1'b1, 8'hFF, 64'h1122334455667788, rd, er, k, ke, bok);
        txn(64'h0, 1'b0, 8'h00, 64'h0, rd, er, k, ke, bok);
        check("rd_lat",   64'(k), 64'(ke));
        check("rd_busy",  {63'd0, bok}, 64'd1);
        check("rd_err",   {63'd0, er},  64'd0);
        check("rd_data",  rd, 64'h1122334455667788);
        @(negedge clk);
        check("gnt_one_cycle", {63'd0, gnt}, 64'd0);
        check("rdata_hold", rdata, 64'h1122334455667788);

        // Strobed write then read
        txn(64'h8, 1'b1, 8'hFF, 64'h0, rd, er, k, ke, bok);
        txn(64'h8, 1'b1, 8'h0F, 64'hFFFFFFFF_AABBCCDD, rd, er, k, ke, bok);
        check("wr_err",     {63'd0, er}, 64'd0);
        check("wr_oldread", rd, 64'h0);
        txn(64'h8, 1'b0, 8'h00, 64'h0, rd, er, k, ke, bok);
        check("strb_rd", rd, 64'h00000000_AABBCCDD);

        // Out of range
        txn(64'h2000, 1'b0, 8'h00, 64'h0, rd, er, k, ke, bok);
        check("oor_rd_err",  {63'd0, er}, 64'd1);
        check("oor_rd_data", rd, 64'h0);
        @(negedge clk);
        check("err_outside_resp", {63'd0, err}, 64'd0);
        txn(64'h2000, 1'b1, 8'hFF, 64'hDEAD_DEAD_DEAD_DEAD, rd, er, k, ke, bok);
        check("oor_wr_err", {63'd0, er}, 64'd1);
        txn(64'h0, 1'b0, 8'h00, 64'h0, rd, er, k, ke, bok);
        check("oor_word0", rd, 64'h1122334455667788);
        txn(64'h1FF8, 1'b0, 8'h00, 64'h0, rd, er, k, ke, bok);
        check("last_word_err", {63'd0, er}, 64'd0);

        // Write with zero strobes leaves RAM unchanged
        txn(64'h0, 1'b1, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF, rd, er, k, ke, bok);
        check("strb0_err", {63'd0, er}, 64'd0);
        txn(64'h0, 1'b0, 8'h00, 64'h0, rd, er, k, ke, bok);
        check("strb0_rd", rd, 64'h1122334455667788);
        check("proto_clean", {63'd0, proto}, 64'd0);

        // Protocol violation: address changes during WAIT
        txn(64'h10, 1'b1, 8'hFF, 64'hDEADBEEF_00000010, rd, er, k, ke, bok);
        txn(64'h18, 1'b1, 8'hFF, 64'h0BADF00D_00000018, rd, er, k, ke, bok);
        @(negedge clk);
        req = 1'b1; addr = 64'h10; wen = 1'b0; strb = '0; wdata = '0;
        c0 = cyc;
        @(negedge clk);
        check("proto_pre", {63'd0, proto}, 64'd0);
        addr = 64'h18;
        @(negedge clk);
        check("proto_set", {63'd0, proto}, 64'd1);
        k = 2;
        while (!gnt && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("proto_lat", 64'(k), 64'(3 + extra(c0)));
        check("proto_data", rdata, 64'hDEADBEEF_00000010);
        @(posedge clk); #1;
        req = 1'b0; addr = '0;
        repeat (3) @(negedge clk);
        check("proto_sticky", {63'd0, proto}, 64'd1);

        // Reset mid-transaction
        txn(64'h20, 1'b1, 8'hFF, 64'h0, rd, er, k, ke, bok);
        @(negedge clk);
        req = 1'b1; addr = 64'h20; wen = 1'b1; strb = 8'hFF; wdata = 64'h5A;
        @(negedge clk);
        check("rstmid_busy_pre", {63'd0, busy}, 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        req = 1'b0; wen = 1'b0; strb = '0;
        check("rstmid_busy", {63'd0, busy}, 64'd0);
        any_gnt = gnt;
        repeat (5) begin
            @(negedge clk);
            any_gnt = any_gnt | gnt;
        end
        check("rstmid_no_gnt", {63'd0, any_gnt}, 64'd0);
        check("rstmid_proto",  {63'd0, proto},   64'd0);
        txn(64'h20, 1'b0, 8'h00, 64'h0, rd, er, k, ke, bok);
        check("rstmid_rd", rd, 64'h0);

        // Back-to-back on the LATENCY=0 instance, req held high
        @(negedge clk);
        req0 = 1'b1; addr0 = 64'h0;
        c0 = cyc; ng = 0; k = 0;
        g[0] = 0; g[1] = 0;
        while (ng < 2 && k < 80) begin
            @(negedge clk);
            k++;
            if (gnt0) begin
                g[ng] = cyc;
                ng++;
            end
        end
        @(posedge clk); #1;
        req0 = 1'b0;
        check("b2b_count", 64'(ng), 64'd2);
        if (ng == 2) begin
            check("b2b_first",  64'(g[0] - c0), 64'(2 + extra(c0)));
            check("b2b_second", 64'(g[1] - g[0]), 64'(3 + extra(g[0] + 1)));
        end
        check("b2b_err", {63'd0, err0}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
